// File: rtl/mips_cpu_load_unit.sv
// Load-path stage: issues one word read, aligns/extends the returned data and drives the
// register-file write controls. All outputs are registered.
module mips_cpu_load_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  input  logic [4:0]  dest_reg,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        rf_orwrite,
  output logic [1:0]  rf_shiftdata,
  output logic        rf_loadlorloadr,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] LdLb  = 3'd0;
  localparam logic [2:0] LdLh  = 3'd1;
  localparam logic [2:0] LdLwl = 3'd2;
  localparam logic [2:0] LdLw  = 3'd3;
  localparam logic [2:0] LdLbu = 3'd4;
  localparam logic [2:0] LdLhu = 3'd5;
  localparam logic [2:0] LdLwr = 3'd6;
  localparam logic [2:0] LdBad = 3'd7;

  typedef enum logic [1:0] {StIdle, StReq, StWb, StErr} state_e;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_q, mem_read_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_reg_q, rf_reg_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic        rf_or_q, rf_or_d;
  logic [1:0]  rf_sh_q, rf_sh_d;
  logic        rf_lr_q, rf_lr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        bad_req;
  logic [3:0]  req_be;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [1:0]  merge_sh;
  logic [31:0] aligned;

  // Request decode on the raw inputs, used only when accepting a start in IDLE.
  always_comb begin
    bad_req = 1'b0;
    req_be  = 4'b1111;
    case (load_type)
      LdLb, LdLbu: req_be = 4'b0001 << addr[1:0];
      LdLh, LdLhu: begin
        req_be  = addr[1] ? 4'b1100 : 4'b0011;
        bad_req = addr[0];
      end
      LdLw:    bad_req = (addr[1:0] != 2'b00);
      LdBad:   bad_req = 1'b1;
      default: req_be = 4'b1111;
    endcase
  end

  // Alignment of the returned word using the latched type and byte offset.
  always_comb begin
    lane_b   = mem_readdata[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    merge_sh = 2'd3 - off_q;
    case (type_q)
      LdLb:    aligned = {{24{lane_b[7]}}, lane_b};
      LdLbu:   aligned = {24'b0, lane_b};
      LdLh:    aligned = {{16{lane_h[15]}}, lane_h};
      LdLhu:   aligned = {16'b0, lane_h};
      LdLwl:   aligned = mem_readdata << {merge_sh, 3'b000};
      LdLwr:   aligned = mem_readdata >> {off_q, 3'b000};
      default: aligned = mem_readdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    off_d         = off_q;
    dest_d        = dest_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    mem_be_d      = mem_be_q;
    rf_we_d       = 1'b0;
    rf_reg_d      = rf_reg_q;
    rf_data_d     = rf_data_q;
    rf_or_d       = rf_or_q;
    rf_sh_d       = rf_sh_q;
    rf_lr_d       = rf_lr_q;
    done_d        = 1'b0;
    error_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          type_d = load_type;
          off_d  = addr[1:0];
          dest_d = dest_reg;
          cnt_d  = '0;
          if (bad_req) begin
            state_d = StErr;
            error_d = 1'b1;
          end else begin
            state_d       = StReq;
            mem_read_d    = 1'b1;
            mem_address_d = {addr[31:2], 2'b00};
            mem_be_d      = req_be;
          end
        end
      end
      StReq: begin
        if (!mem_waitrequest) begin
          state_d    = StWb;
          mem_read_d = 1'b0;
          rf_we_d    = (dest_q != 5'd0);
          rf_reg_d   = dest_q;
          rf_data_d  = aligned;
          rf_or_d    = (type_q == LdLwl) || (type_q == LdLwr);
          rf_sh_d    = rf_or_d ? merge_sh : 2'd0;
          rf_lr_d    = (type_q == LdLwr);
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if ((TIMEOUT != 0) && (cnt_d >= TIMEOUT)) begin
            state_d    = StErr;
            mem_read_d = 1'b0;
            error_d    = 1'b1;
          end
        end
      end
      StWb:    state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      type_q        <= '0;
      off_q         <= '0;
      dest_q        <= '0;
      cnt_q         <= '0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_be_q      <= '0;
      rf_we_q       <= 1'b0;
      rf_reg_q      <= '0;
      rf_data_q     <= '0;
      rf_or_q       <= 1'b0;
      rf_sh_q       <= '0;
      rf_lr_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      off_q         <= off_d;
      dest_q        <= dest_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_be_q      <= mem_be_d;
      rf_we_q       <= rf_we_d;
      rf_reg_q      <= rf_reg_d;
      rf_data_q     <= rf_data_d;
      rf_or_q       <= rf_or_d;
      rf_sh_q       <= rf_sh_d;
      rf_lr_q       <= rf_lr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign mem_address     = mem_address_q;
  assign mem_read        = mem_read_q;
  assign mem_byteenable  = mem_be_q;
  assign rf_write_enable = rf_we_q;
  assign rf_write_reg    = rf_reg_q;
  assign rf_write_data   = rf_data_q;
  assign rf_orwrite      = rf_or_q;
  assign rf_shiftdata    = rf_sh_q;
  assign rf_loadlorloadr = rf_lr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_mips_cpu_load_unit.sv
// Directed bench for mips_cpu_load_unit: a byte-level model of the load rules sets per-cycle
// expectations that one negedge process compares against the DUT.
module tb_mips_cpu_load_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset, start, mem_waitrequest;
  logic [2:0]  load_type;
  logic [31:0] addr, mem_readdata;
  logic [4:0]  dest_reg;
  logic [31:0] mem_address, rf_write_data;
  logic        mem_read, rf_write_enable, rf_orwrite, rf_loadlorloadr, busy, done, error;
  logic [3:0]  mem_byteenable;
  logic [4:0]  rf_write_reg;
  logic [1:0]  rf_shiftdata;

  mips_cpu_load_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .load_type(load_type), .addr(addr),
    .dest_reg(dest_reg), .mem_address(mem_address), .mem_read(mem_read),
    .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .rf_write_enable(rf_write_enable),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_orwrite(rf_orwrite),
    .rf_shiftdata(rf_shiftdata), .rf_loadlorloadr(rf_loadlorloadr), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Expected values for the current cycle
  logic        chk_en = 1'b0, chk_bus = 1'b0, lit_en = 1'b0;
  logic        e_read, e_we, e_done, e_err, e_busy, e_or, e_lr;
  logic [31:0] e_addr, e_data, lit_data;
  logic [3:0]  e_be;
  logic [4:0]  e_reg;
  logic [1:0]  e_sh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_read", 32'(mem_read), 32'(e_read));
      check("rf_write_enable", 32'(rf_write_enable), 32'(e_we));
      check("rf_write_reg", 32'(rf_write_reg), 32'(e_reg));
      check("rf_write_data", rf_write_data, e_data);
      check("rf_orwrite", 32'(rf_orwrite), 32'(e_or));
      check("rf_shiftdata", 32'(rf_shiftdata), 32'(e_sh));
      check("rf_loadlorloadr", 32'(rf_loadlorloadr), 32'(e_lr));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("error", 32'(error), 32'(e_err));
      if (chk_bus) begin
        check("mem_address", mem_address, e_addr);
        check("mem_byteenable", 32'(mem_byteenable), 32'(e_be));
      end
      if (lit_en) check("literal_data", rf_write_data, lit_data);
    end
  end

  // ---- model ----
  function automatic logic model_err(input logic [2:0] t, input int o);
    return (t == 3'd7) || ((t == 3'd1 || t == 3'd5) && (o % 2 == 1)) || (t == 3'd3 && o != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] t, input int o);
    logic [3:0] be = '0;
    int size, first;
    if (t == 3'd0 || t == 3'd4) begin size = 1; first = o; end
    else if (t == 3'd1 || t == 3'd5) begin size = 2; first = o; end
    else begin size = 4; first = 0; end
    for (int i = 0; i < size; i++) be[first + i] = 1'b1;
    return be;
  endfunction

  task automatic model_wb(input logic [2:0] t, input int o, input logic [31:0] rd,
                          output logic [31:0] data, output logic ow, output logic [1:0] sh,
                          output logic lr);
    logic [7:0] b [4];
    int n;
    for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
    ow = 1'b0; sh = 2'd0; lr = 1'b0; data = '0;
    case (t)
      3'd0: data = 32'($signed(b[o]));
      3'd4: data = {24'b0, b[o]};
      3'd1: data = 32'($signed({b[o+1], b[o]}));
      3'd5: data = {16'b0, b[o+1], b[o]};
      3'd2: begin
        n = 3 - o;
        for (int j = 0; j < 4; j++) data[8*j +: 8] = (j >= n) ? b[j-n] : 8'h00;
        ow = 1'b1; sh = 2'(n);
      end
      3'd6: begin
        for (int j = 0; j < 4; j++) data[8*j +: 8] = (j + o <= 3) ? b[j+o] : 8'h00;
        ow = 1'b1; sh = 2'(3 - o); lr = 1'b1;
      end
      default: data = rd;
    endcase
  endtask

  // ---- stimulus ----
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_read = 1'b0; e_we = 1'b0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    chk_bus = 1'b0; lit_en = 1'b0;
  endtask

  // Starts in the IDLE cycle and returns at the end of the WB or ERR cycle.
  task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] d,
                         input logic [31:0] rd, input int stalls, input logic lit_chk,
                         input logic [31:0] lit);
    int o = int'(a[1:0]);
    int k = 0;
    next_cycle();
    start = 1'b1; load_type = t; addr = a; dest_reg = d; mem_waitrequest = 1'b1;
    set_idle_exp();
    next_cycle();
    // Requests while busy must be ignored
    load_type = 3'd7; addr = 32'hFFFF_FFFF; dest_reg = 5'd31;
    e_busy = 1'b1;
    if (model_err(t, o)) begin
      e_err = 1'b1;
      return;
    end
    e_read = 1'b1; chk_bus = 1'b1; e_addr = {a[31:2], 2'b00}; e_be = model_be(t, o);
    forever begin
      mem_waitrequest = (k < stalls);
      mem_readdata = (k < stalls) ? 32'h0BAD_F00D : rd;
      if (!mem_waitrequest) break;
      if (k + 1 == int'(TO)) begin
        next_cycle();
        start = 1'b0;
        e_read = 1'b0; chk_bus = 1'b0; e_err = 1'b1;
        return;
      end
      next_cycle();
      k++;
    end
    next_cycle();
    start = 1'b0; mem_waitrequest = 1'b1; mem_readdata = 32'h0;
    e_read = 1'b0; chk_bus = 1'b0; e_done = 1'b1; e_we = (d != 5'd0); e_reg = d;
    model_wb(t, o, rd, e_data, e_or, e_sh, e_lr);
    lit_en = lit_chk; lit_data = lit;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; load_type = '0; addr = '0; dest_reg = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0;
    set_idle_exp();
    e_reg = '0; e_data = '0; e_or = 1'b0; e_sh = '0; e_lr = 1'b0; e_addr = '0; e_be = '0;
    lit_data = '0;
    next_cycle();
    next_cycle();
    chk_en = 1'b1; chk_bus = 1'b1;  // reset state: every output 0
    next_cycle();
    reset = 1'b1;
    next_cycle();
    chk_bus = 1'b0;

    do_load(3'd3, 32'h0000_0100, 5'd5, 32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF);
    do_load(3'd0, 32'h0000_0103, 5'd6, 32'h8011_2233, 0, 1'b1, 32'hFFFF_FF80);
    do_load(3'd4, 32'h0000_0103, 5'd7, 32'h8011_2233, 0, 1'b1, 32'h0000_0080);
    do_load(3'd5, 32'h0000_0102, 5'd8, 32'hBEEF_1234, 3, 1'b1, 32'h0000_BEEF);
    do_load(3'd2, 32'h0000_0101, 5'd9, 32'hAABB_CCDD, 0, 1'b1, 32'hCCDD_0000);
    do_load(3'd6, 32'h0000_0101, 5'd10, 32'hAABB_CCDD, 0, 1'b1, 32'h00AA_BBCC);
    do_load(3'd1, 32'h0000_0101, 5'd11, 32'h1234_5678, 0, 1'b0, 32'h0);
    do_load(3'd7, 32'h0000_0100, 5'd12, 32'h1234_5678, 0, 1'b0, 32'h0);
    do_load(3'd3, 32'h0000_0102, 5'd13, 32'h1234_5678, 0, 1'b0, 32'h0);
    do_load(3'd1, 32'h0000_0202, 5'd14, 32'h8001_7FFF, 1, 1'b1, 32'hFFFF_8001);
    do_load(3'd1, 32'h0000_0200, 5'd15, 32'h8001_7FFF, 0, 1'b1, 32'h0000_7FFF);
    do_load(3'd0, 32'h0000_0300, 5'd0, 32'h0000_00F0, 0, 1'b1, 32'hFFFF_FFF0);
    do_load(3'd2, 32'h0000_0400, 5'd1, 32'h1122_3344, 0, 1'b1, 32'h4400_0000);
    do_load(3'd2, 32'h0000_0403, 5'd2, 32'h1122_3344, 2, 1'b1, 32'h1122_3344);
    do_load(3'd6, 32'h0000_0403, 5'd3, 32'h1122_3344, 0, 1'b1, 32'h0000_0011);
    do_load(3'd6, 32'h0000_0400, 5'd4, 32'h1122_3344, 0, 1'b1, 32'h1122_3344);
    do_load(3'd4, 32'h0000_0501, 5'd16, 32'h1122_3344, 0, 1'b1, 32'h0000_0033);
    do_load(3'd3, 32'h0000_0600, 5'd17, 32'h5555_AAAA, 50, 1'b0, 32'h0);  // timeout
    do_load(3'd5, 32'h0000_0600, 5'd18, 32'hFEDC_BA98, 3, 1'b1, 32'h0000_BA98);

    // Reset asserted while REQ is stalled
    next_cycle();
    set_idle_exp();
    start = 1'b1; load_type = 3'd3; addr = 32'h0000_0700; dest_reg = 5'd19;
    mem_waitrequest = 1'b1;
    next_cycle();
    start = 1'b0;
    e_read = 1'b1; e_busy = 1'b1; chk_bus = 1'b1; e_addr = 32'h0000_0700; e_be = 4'b1111;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    set_idle_exp();
    chk_bus = 1'b1; e_addr = '0; e_be = '0;
    e_reg = '0; e_data = '0; e_or = 1'b0; e_sh = '0; e_lr = 1'b0;
    reset = 1'b1; mem_waitrequest = 1'b0; mem_readdata = 32'hFFFF_FFFF;
    next_cycle();
    chk_bus = 1'b0;
    next_cycle();

    // Stall count must start from zero again after the reset
    do_load(3'd0, 32'h0000_0801, 5'd20, 32'h0000_7F00, 3, 1'b1, 32'h0000_007F);
    next_cycle();
    set_idle_exp();
    next_cycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
